// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader.
//   state_e  : loader FSM states (3-bit encoding, also used by the host image builder)
//   csum_ok  : frame checksum rule, (sum of payload + CSUM) mod 256 == 0
//   lane_be  : byte-enable mask covering lanes 0..lane
// Frame field order on the wire: LEN_LO, LEN_HI, N payload bytes, CSUM.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    StLen0 = 3'd0,
    StLen1 = 3'd1,
    StData = 3'd2,
    StCsum = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
    logic [7:0] total;
    total = sum + csum;
    return total == 8'h00;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    logic [3:0] be;
    unique case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream in, instruction-memory write port out.
//   rx_valid/rx_data/rx_ready : byte stream; transfer = rx_valid & rx_ready
//   mem_we/waddr/wdata/wbe    : word write port, little-endian, word-aligned address
// Modport master is the loader side, slave is the byte source plus memory.
interface instr_loader_if #(
  parameter int unsigned AddrW = 8
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wbe;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_waddr, mem_wdata, mem_wbe
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_waddr, mem_wdata, mem_wbe
  );
endinterface

// File: rtl/instr_loader_word_packer.sv
// Packs accepted payload bytes into little-endian 32-bit words and issues word writes.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : restart packing at lane 0 / address 0
//   byte_valid_i  : byte_i is a payload byte to pack this cycle
//   last_i        : byte_i is the final payload byte, flush the partial word
//   we_o, waddr_o, wdata_o, wbe_o : registered write port, we_o is a 1-cycle pulse
module instr_loader_word_packer
  import instr_loader_pkg::*;
#(
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  input  logic             last_i,
  output logic             we_o,
  output logic [AddrW-1:0] waddr_o,
  output logic [31:0]      wdata_o,
  output logic [3:0]       wbe_o
);

  logic [1:0]       lane_q;
  logic [31:0]      asm_q;
  logic [AddrW-3:0] widx_q;
  logic             we_q;
  logic [AddrW-1:0] waddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wbe_q;

  logic [31:0] word_d;
  logic        flush;

  always_comb begin
    // Unfilled lanes stay zero because asm_q is cleared after every flush.
    word_d = asm_q | (32'(byte_i) << {lane_q, 3'b000});
    flush  = byte_valid_i && ((lane_q == 2'd3) || last_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q  <= 2'd0;
      asm_q   <= 32'd0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      wbe_q   <= 4'd0;
    end else begin
      we_q  <= 1'b0;
      wbe_q <= 4'd0;
      if (clear_i) begin
        lane_q <= 2'd0;
        asm_q  <= 32'd0;
        widx_q <= '0;
      end else if (flush) begin
        we_q    <= 1'b1;
        waddr_q <= {widx_q, 2'b00};
        wdata_q <= word_d;
        wbe_q   <= lane_be(lane_q);
        widx_q  <= widx_q + 1'b1;
        lane_q  <= 2'd0;
        asm_q   <= 32'd0;
      end else if (byte_valid_i) begin
        asm_q  <= word_d;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign wbe_o   = wbe_q;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a framed program image as bytes, writes it to instruction memory
// from address 0 upward and releases the core once the checksum passes.
//   clk_i, rst_i : clock, synchronous active-high reset
//   reload_i     : 1-cycle pulse, restarts loading from done or error
//   bus_io       : byte stream in, memory write port out
//   core_hold_o  : 1 keeps the core in reset
//   done_o       : image loaded and checksum good
//   err_o        : oversize image or checksum mismatch
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned AddrW = 8,
  parameter int unsigned LenW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reload_i,
  instr_loader_if.master         bus_io,
  output logic                   core_hold_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned Cap = 2 ** AddrW;

  state_e          state_q;
  logic [7:0]      len_lo_q;
  logic [LenW-1:0] len_q;
  logic [LenW-1:0] count_q;
  logic [7:0]      sum_q;
  logic            done_q;
  logic            err_q;
  logic            hold_q;

  logic            rx_ready;
  logic            accept;
  logic [LenW-1:0] len_n;
  logic            last;
  logic            restart;

  always_comb begin
    rx_ready = !rst_i && ((state_q == StLen0) || (state_q == StLen1) ||
                          (state_q == StData) || (state_q == StCsum));
    accept   = bus_io.rx_valid && rx_ready;
    len_n    = LenW'({bus_io.rx_data, len_lo_q});
    last     = (count_q == len_q - LenW'(1));
    restart  = reload_i && ((state_q == StDone) || (state_q == StErr));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StLen0;
      len_lo_q <= 8'd0;
      len_q    <= '0;
      count_q  <= '0;
      sum_q    <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StLen0: begin
          if (accept) begin
            len_lo_q <= bus_io.rx_data;
            state_q  <= StLen1;
          end
        end
        StLen1: begin
          if (accept) begin
            len_q <= len_n;
            if (32'(len_n) > Cap) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (len_n == '0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            sum_q   <= sum_q + bus_io.rx_data;
            count_q <= count_q + LenW'(1);
            if (last) state_q <= StCsum;
          end
        end
        StCsum: begin
          if (accept) begin
            if (csum_ok(sum_q, bus_io.rx_data)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
        StDone, StErr: begin
          if (reload_i) begin
            state_q <= StLen0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            count_q <= '0;
            sum_q   <= 8'd0;
          end
        end
        default: state_q <= StLen0;
      endcase
    end
  end

  instr_loader_word_packer #(
    .AddrW (AddrW)
  ) u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (restart),
    .byte_valid_i (accept && (state_q == StData)),
    .byte_i       (bus_io.rx_data),
    .last_i       (last),
    .we_o         (bus_io.mem_we),
    .waddr_o      (bus_io.mem_waddr),
    .wdata_o      (bus_io.mem_wdata),
    .wbe_o        (bus_io.mem_wbe)
  );

  assign bus_io.rx_ready = rx_ready;
  assign core_hold_o     = hold_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic core_hold;
  logic done;
  logic err;

  instr_loader_if #(.AddrW(8)) bus ();

  instr_loader #(
    .AddrW (8),
    .LenW  (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reload_i    (reload),
    .bus_io      (bus),
    .core_hold_o (core_hold),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  exp_q[$];
  wr_t  log_q[$];
  logic [7:0] payload[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Every observed write is matched against the model's expected write queue.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_t got;
      got.addr = bus.mem_waddr;
      got.data = bus.mem_wdata;
      got.be   = bus.mem_wbe;
      log_q.push_back(got);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h be=%h want none",
                 got.addr, got.data, got.be);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", got.addr, e.addr);
        check("write_data", got.data, e.data);
        check("write_be", got.be, e.be);
      end
    end else if (bus.mem_we !== 1'b0) begin
      check("mem_we_known", bus.mem_we, 1'b0);
    end
  end

  // Model: split the payload into 4-byte little-endian words at 4*i.
  task automatic model_writes();
    int n;
    n = payload.size();
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.addr = 8'(w * 4);
      e.data = 32'd0;
      e.be   = 4'd0;
      for (int k = 0; k < 4 && (w * 4 + k) < n; k++) begin
        e.data[8*k +: 8] = payload[w*4+k];
        e.be[k]          = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [7:0] good_csum();
    logic [7:0] s;
    s = 8'd0;
    foreach (payload[i]) s = s + payload[i];
    return 8'd0 - s;
  endfunction

  // Drives one byte starting at posedge+1 and returns at posedge+1 after it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int tries;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tries = 0;
    while (bus.rx_ready !== 1'b1 && tries < 8) begin
      @(posedge clk);
      #1;
      tries++;
    end
    if (tries == 8) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b want 1", bus.rx_ready);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] csum);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (payload[i]) send_byte(payload[i]);
    send_byte(csum);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", bus.rx_ready, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_waddr", bus.mem_waddr, 8'h00);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_wbe", bus.mem_wbe, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_hold", core_hold, 1'b1);
    rst = 1'b0;
    #1;
    check("post_rst_rx_ready", bus.rx_ready, 1'b1);
  endtask

  task automatic do_reload(input logic with_byte);
    check("pre_reload_rx_ready", bus.rx_ready, 1'b0);
    reload       = 1'b1;
    bus.rx_valid = with_byte;
    bus.rx_data  = 8'h05;
    @(posedge clk);
    #1;
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    check("reload_hold", core_hold, 1'b1);
    check("reload_done", done, 1'b0);
    check("reload_err", err, 1'b0);
    check("reload_rx_ready", bus.rx_ready, 1'b1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic check_log(input int idx, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    if (log_q.size() > idx) begin
      check("lit_addr", log_q[idx].addr, a);
      check("lit_data", log_q[idx].data, d);
      check("lit_be", log_q[idx].be, be);
    end else begin
      check("lit_present", log_q.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: N=8, correct checksum (sum 0xAB -> CSUM 0x55)
    payload = '{8'h93, 8'h02, 8'h00, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00};
    model_writes();
    log_q.delete();
    send_frame(16'd8, 8'h55);
    check("t1_done", done, 1'b1);
    check("t1_err", err, 1'b0);
    check("t1_hold", core_hold, 1'b0);
    check("t1_rx_ready", bus.rx_ready, 1'b0);
    settle();
    check("t1_nwrites", log_q.size(), 2);
    check_log(0, 8'h00, 32'h0000_0293, 4'hF);
    check_log(1, 8'h04, 32'h0000_0313, 4'hF);

    // 2: N=5, payload 01..05 (sum 0x0F -> CSUM 0xF1)
    do_reload(1'b0);
    payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    model_writes();
    log_q.delete();
    send_frame(16'd5, 8'hF1);
    check("t2_done", done, 1'b1);
    settle();
    check("t2_nwrites", log_q.size(), 2);
    check_log(0, 8'h00, 32'h0403_0201, 4'hF);
    check_log(1, 8'h04, 32'h0000_0005, 4'h1);

    // 3: frame 1 with bad checksum, writes still happen
    do_reload(1'b0);
    payload = '{8'h93, 8'h02, 8'h00, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00};
    model_writes();
    log_q.delete();
    send_frame(16'd8, good_csum() + 8'd1);
    check("t3_err", err, 1'b1);
    check("t3_done", done, 1'b0);
    check("t3_hold", core_hold, 1'b1);
    check("t3_rx_ready", bus.rx_ready, 1'b0);
    settle();
    check("t3_nwrites", log_q.size(), 2);

    // 4: oversize N=0x0101, error right after LEN_HI, no writes
    do_reload(1'b0);
    payload.delete();
    log_q.delete();
    send_byte(8'h01);
    send_byte(8'h01);
    check("t4_err", err, 1'b1);
    check("t4_hold", core_hold, 1'b1);
    check("t4_rx_ready", bus.rx_ready, 1'b0);
    settle();
    check("t4_nwrites", log_q.size(), 0);

    // 5: reset after 3 payload bytes, then a fresh N=4 frame
    do_reload(1'b0);
    log_q.delete();
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model_writes();
    send_frame(16'd4, good_csum());
    check("t5_done", done, 1'b1);
    settle();
    check("t5_nwrites", log_q.size(), 1);
    check_log(0, 8'h00, 32'hDDCC_BBAA, 4'hF);

    // 6: reload with a byte offered the same cycle, then an empty frame
    do_reload(1'b1);
    payload.delete();
    log_q.delete();
    send_frame(16'd0, 8'h00);
    check("t6_done", done, 1'b1);
    check("t6_hold", core_hold, 1'b0);
    settle();
    check("t6_nwrites", log_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
